// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between the processor load/store port
//   (requester 0) and the program-loader/debug port (requester 1). At most one
//   access is granted per cycle. The current owner keeps the port while it
//   keeps requesting, but only for MAX_BURST consecutive grants while the
//   other side is waiting. After that the port passes to the other requester.
//   An IDLE-state tie goes to the requester that did not win last.
//
// Parameters
//   MAX_BURST  consecutive contended grants per owner, legal range 1..15
//
// Ports
//   clk, nrst                    clock, synchronous active-low reset
//   req0/1, addr0/1, wr_en0/1,   requester-side access request; a request is
//   wdata0/1, wmask0/1           held until its gnt is seen
//   gnt0/1                       combinational accept for this cycle
//   rvalid0/1, rdata0/1          read return, one cycle after the read grant
//   mem_addr, mem_wr_en,         memory-side request of the winner (all zero
//   mem_wdata, mem_wmask         when nothing is granted)
//   mem_rdata                    memory read data, one cycle after the address
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic        wr_en0,
  input  logic [63:0] wdata0,
  input  logic [7:0]  wmask0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [63:0] rdata0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic        wr_en1,
  input  logic [63:0] wdata1,
  input  logic [7:0]  wmask1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [63:0] rdata1,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  state_e     state_q,      state_d;
  logic [3:0] burst_cnt_q,  burst_cnt_d;
  logic       last_owner_q, last_owner_d;
  logic       rvalid0_q,    rvalid0_d;
  logic       rvalid1_q,    rvalid1_d;

  logic       win_vld;   // some requester is granted this cycle
  logic       win_id;    // which one (0 or 1)
  logic       free_vld;  // winner when nobody holds the port
  logic       free_id;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    win_vld     = 1'b0;
    win_id      = 1'b0;
    burst_cnt_d = 4'd1;

    // Free-port pick: a lone requester wins; a tie goes to whoever did not
    // win last (last_owner resets to 1, so requester 0 takes the first tie).
    free_vld = req0 | req1;
    free_id  = (req0 && req1) ? ~last_owner_q : req1;

    case (state_q)
      OWN0: begin
        if (req0) begin
          win_vld = 1'b1;
          if (!req1) begin
            // Uncontended: no burst limit, counter parked at 1.
            win_id = 1'b0;
          end else if (burst_cnt_q < MAX_BURST_C) begin
            win_id      = 1'b0;
            burst_cnt_d = burst_cnt_q + 4'd1;
          end else begin
            // Burst exhausted while requester 1 waits: hand over.
            win_id = 1'b1;
          end
        end else begin
          win_vld = free_vld;
          win_id  = free_id;
        end
      end
      OWN1: begin
        if (req1) begin
          win_vld = 1'b1;
          if (!req0) begin
            win_id = 1'b1;
          end else if (burst_cnt_q < MAX_BURST_C) begin
            win_id      = 1'b1;
            burst_cnt_d = burst_cnt_q + 4'd1;
          end else begin
            win_id = 1'b0;
          end
        end else begin
          win_vld = free_vld;
          win_id  = free_id;
        end
      end
      default: begin
        win_vld = free_vld;
        win_id  = free_id;
      end
    endcase

    // No grant at all while reset is held, so no write can reach memory.
    if (!nrst) begin
      win_vld = 1'b0;
    end

    if (!win_vld) begin
      state_d = IDLE;
    end else if (win_id) begin
      state_d = OWN1;
    end else begin
      state_d = OWN0;
    end

    last_owner_d = win_vld ? win_id : last_owner_q;

    // A read return is flagged only for granted reads; writes return nothing.
    rvalid0_d = win_vld && !win_id && !wr_en0;
    rvalid1_d = win_vld &&  win_id && !wr_en1;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!nrst) begin
      state_q      <= IDLE;
      burst_cnt_q  <= 4'd1;
      last_owner_q <= 1'b1;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_owner_q <= last_owner_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign gnt0 = win_vld && !win_id;
  assign gnt1 = win_vld &&  win_id;

  // Memory-side request is the winner's; all zero when idle.
  assign mem_addr  = !win_vld ? 32'd0 : (win_id ? addr1  : addr0);
  assign mem_wr_en = !win_vld ? 1'b0  : (win_id ? wr_en1 : wr_en0);
  assign mem_wdata = !win_vld ? 64'd0 : (win_id ? wdata1 : wdata0);
  assign mem_wmask = !win_vld ? 8'd0  : (win_id ? wmask1 : wmask0);

  // Read data goes to both sides; the rvalid tag says whose it is.
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a small byte-masked memory model
//   (16 words, indexed by addr[6:3], read data registered one cycle).
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   2 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        wr_en0, wr_en1;
  logic [63:0] wdata0, wdata1;
  logic [7:0]  wmask0, wmask1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic [63:0] rdata0, rdata1;
  logic [31:0] mem_addr;
  logic        mem_wr_en;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_BURST(4)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .req0     (req0),
    .addr0    (addr0),
    .wr_en0   (wr_en0),
    .wdata0   (wdata0),
    .wmask0   (wmask0),
    .gnt0     (gnt0),
    .rvalid0  (rvalid0),
    .rdata0   (rdata0),
    .req1     (req1),
    .addr1    (addr1),
    .wr_en1   (wr_en1),
    .wdata1   (wdata1),
    .wmask1   (wmask1),
    .gnt1     (gnt1),
    .rvalid1  (rvalid1),
    .rdata1   (rdata1),
    .mem_addr (mem_addr),
    .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata)
  );

  // Memory model: byte-masked write at the edge, read data one cycle later.
  logic [63:0] mem [16];

  always @(posedge clk) begin
    if (!nrst) begin
      for (int w = 0; w < 16; w++) mem[w] <= 64'd0;
      mem_rdata <= 64'd0;
    end else begin
      if (mem_wr_en) begin
        for (int b = 0; b < 8; b++) begin
          if (mem_wmask[b]) mem[mem_addr[6:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
      mem_rdata <= mem[mem_addr[6:3]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Move to the input-drive point of the next cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Safety net: the directed sequence is a few hundred time units long.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp0;
    logic prev0;

    nrst   = 1'b0;
    req0   = 1'b1;
    addr0  = 32'h40;
    wr_en0 = 1'b1;
    wdata0 = 64'h1111_2222_3333_4444;
    wmask0 = 8'hFF;
    req1   = 1'b0;
    addr1  = 32'h0;
    wr_en1 = 1'b0;
    wdata1 = 64'h0;
    wmask1 = 8'h0;
    prev0  = 1'b0;

    // --- Reset held with a pending write: nothing may be granted ---
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check_b("rst_gnt0", gnt0, 1'b0);
      check_b("rst_mem_wr_en", mem_wr_en, 1'b0);
      check_b("rst_rvalid0", rvalid0, 1'b0);
      check_b("rst_rvalid1", rvalid1, 1'b0);
    end

    // Release: the held write is granted immediately.
    nrst = 1'b1;
    #1;
    check_b("rel_gnt0", gnt0, 1'b1);
    check("rel_mem_addr", 64'(mem_addr), 64'h40);

    // --- Requester 0 write then read of 0x10 ---
    next_cycle();
    addr0  = 32'h10;
    wdata0 = 64'hDEADBEEF_01234567;
    #1;
    check_b("wr_gnt0", gnt0, 1'b1);
    check_b("wr_mem_wr_en", mem_wr_en, 1'b1);
    check("wr_mem_addr", 64'(mem_addr), 64'h10);
    check("wr_mem_wdata", mem_wdata, 64'hDEADBEEF_01234567);
    check("wr_mem_wmask", 64'(mem_wmask), 64'hFF);

    next_cycle();
    wr_en0 = 1'b0;
    #1;
    check_b("rd_gnt0", gnt0, 1'b1);
    check_b("rd_mem_wr_en", mem_wr_en, 1'b0);
    check_b("wr_no_rvalid0", rvalid0, 1'b0);

    next_cycle();
    req0 = 1'b0;
    #1;
    check_b("rd_rvalid0", rvalid0, 1'b1);
    check("rd_rdata0", rdata0, 64'hDEADBEEF_01234567);
    check_b("idle_gnt0", gnt0, 1'b0);
    check("idle_mem_addr", 64'(mem_addr), 64'h0);
    check("idle_mem_wdata", mem_wdata, 64'h0);
    check("idle_mem_wmask", 64'(mem_wmask), 64'h0);

    next_cycle();
    check_b("rvalid0_one_cycle", rvalid0, 1'b0);

    // --- Tie after reset: 4 grants to 0, 4 to 1, then back to 0 ---
    nrst = 1'b0;
    next_cycle();
    nrst   = 1'b1;
    req0   = 1'b1;
    req1   = 1'b1;
    wr_en0 = 1'b0;
    wr_en1 = 1'b0;
    addr0  = 32'h10;
    addr1  = 32'h20;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp0 = ((i / 4) % 2) == 0;
      check_b("tie_gnt0", gnt0, exp0);
      check_b("tie_gnt1", gnt1, ~exp0);
      if (i > 0) begin
        check_b("tie_rvalid0", rvalid0, prev0);
        check_b("tie_rvalid1", rvalid1, ~prev0);
      end
      prev0 = exp0;
      next_cycle();
    end

    // --- Requester 1 alone for 10 cycles: no burst limit ---
    req0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_b("solo_gnt1", gnt1, 1'b1);
      next_cycle();
    end

    // Requester 0 joins: owner 1 takes 3 more (counter 1..3), then 0 wins.
    req0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_b("join_gnt0", gnt0, k == 3);
      check_b("join_gnt1", gnt1, k < 3);
      next_cycle();
    end

    // --- Partial mask write by requester 1 to zeroed word 0x30 ---
    req0   = 1'b0;
    addr1  = 32'h30;
    wr_en1 = 1'b1;
    wdata1 = 64'hFFFFFFFF_FFFFFFFF;
    wmask1 = 8'h0F;
    #1;
    check_b("pm_gnt1", gnt1, 1'b1);
    check("pm_mem_wmask", 64'(mem_wmask), 64'h0F);

    next_cycle();
    wr_en1 = 1'b0;
    #1;
    check_b("pm_rd_gnt1", gnt1, 1'b1);

    // This cycle both returns the partial-mask read and grants a new read
    // to requester 1, which reset will interrupt.
    next_cycle();
    #1;
    check_b("pm_rvalid1", rvalid1, 1'b1);
    check("pm_rdata1", rdata1, 64'h00000000_FFFFFFFF);
    check_b("mr_gnt1", gnt1, 1'b1);

    // --- Reset in the cycle after a read grant ---
    next_cycle();
    nrst = 1'b0;
    req0 = 1'b1;
    #1;
    check_b("mr_rst_gnt0", gnt0, 1'b0);
    check_b("mr_rst_gnt1", gnt1, 1'b0);
    check_b("mr_rst_mem_wr_en", mem_wr_en, 1'b0);

    next_cycle();
    nrst = 1'b1;
    #1;
    check_b("mr_rvalid1", rvalid1, 1'b0);
    check_b("mr_tie_gnt0", gnt0, 1'b1);
    check_b("mr_tie_gnt1", gnt1, 1'b0);

    next_cycle();
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    check_b("mr_rvalid0", rvalid0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
